// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field geometry, reset PC and fetch state encoding.
package cpu_pkg;

   localparam int OPCODE_W  = 4;
   localparam int FUNC_W    = 3;
   localparam int REG_IDX_W = 3;
   localparam int IMM_W     = 6;

   localparam int OPCODE_LSB = 12;
   localparam int RS_LSB     = 9;
   localparam int RT_LSB     = 6;
   localparam int RD_LSB     = 3;
   localparam int FUNC_LSB   = 0;
   localparam int IMM_LSB    = 0;

   localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_REQ  = 2'd1,
      FETCH_HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_instr_reg.sv
// Instruction register with load enable; decoded fields are plain slices of the held word.
module instr_reg
   import cpu_pkg::*;
#(
   parameter int INSTR_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_i,
   input  logic [INSTR_W-1:0]   data_i,
   output logic [OPCODE_W-1:0]  opcode_o,
   output logic [FUNC_W-1:0]    func_o,
   output logic [REG_IDX_W-1:0] rs_o,
   output logic [REG_IDX_W-1:0] rt_o,
   output logic [REG_IDX_W-1:0] rd_o,
   output logic [IMM_W-1:0]     imm_o
);

   logic [INSTR_W-1:0] ir_q;

   // NOTE: the IR is reset so the decoded fields never show X before the first fetch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ir_q <= '0;
      end else if (load_i) begin
         ir_q <= data_i;
      end
   end

   assign opcode_o = ir_q[OPCODE_LSB +: OPCODE_W];
   assign rs_o     = ir_q[RS_LSB     +: REG_IDX_W];
   assign rt_o     = ir_q[RT_LSB     +: REG_IDX_W];
   assign rd_o     = ir_q[RD_LSB     +: REG_IDX_W];
   assign func_o   = ir_q[FUNC_LSB   +: FUNC_W];
   assign imm_o    = ir_q[IMM_LSB    +: IMM_W];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs the req/ack memory port, holds one instruction for decode
// and absorbs branch/jump redirects from execute.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter int                INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 imem_req,
   output logic [ADDR_W-1:0]    imem_addr,
   input  logic                 imem_ack,
   input  logic [INSTR_W-1:0]   imem_rdata,
   output logic                 instr_valid,
   input  logic                 instr_ready,
   output logic [OPCODE_W-1:0]  opCode,
   output logic [FUNC_W-1:0]    func,
   output logic [REG_IDX_W-1:0] rs,
   output logic [REG_IDX_W-1:0] rt,
   output logic [REG_IDX_W-1:0] rd,
   output logic [IMM_W-1:0]     imm,
   output logic [ADDR_W-1:0]    pc_out,
   input  logic                 redirect,
   input  logic [ADDR_W-1:0]    redirect_pc
);

   fetch_state_e      state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_inc_d;
   logic [ADDR_W-1:0] pc_out_q;
   logic [ADDR_W-1:0] pend_pc_q;
   logic              pend_q;
   logic              req_q;
   logic              valid_q;
   logic              ir_load_d;

   assign pc_inc_d = pc_q + ADDR_W'(1);

   // Data is only kept when no redirect touched this request, now or earlier.
   assign ir_load_d = (state_q == FETCH_REQ) && imem_ack && !redirect && !pend_q;

   // NOTE: all state is updated with <= so every branch reads the pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= FETCH_IDLE;
         pc_q      <= RESET_PC;
         pc_out_q  <= '0;
         pend_pc_q <= '0;
         pend_q    <= 1'b0;
         req_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         case (state_q)
            FETCH_IDLE: begin
               if (redirect) pc_q <= redirect_pc;
               state_q <= FETCH_REQ;
               req_q   <= 1'b1;
            end
            FETCH_REQ: begin
               if (imem_ack) begin
                  if (redirect || pend_q) begin
                     pc_q   <= redirect ? redirect_pc : pend_pc_q;
                     pend_q <= 1'b0;
                  end else begin
                     pc_out_q <= pc_q;
                     pc_q     <= pc_inc_d;
                     state_q  <= FETCH_HOLD;
                     req_q    <= 1'b0;
                     valid_q  <= 1'b1;
                  end
               end else if (redirect) begin
                  // Address stays stable mid-request; the target waits for the ack.
                  pend_q    <= 1'b1;
                  pend_pc_q <= redirect_pc;
               end
            end
            FETCH_HOLD: begin
               if (redirect || instr_ready) begin
                  if (redirect) pc_q <= redirect_pc;
                  valid_q <= 1'b0;
                  state_q <= FETCH_REQ;
                  req_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= FETCH_IDLE;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   instr_reg #(
      .INSTR_W (INSTR_W)
   ) u_instr_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (ir_load_d),
      .data_i   (imem_rdata),
      .opcode_o (opCode),
      .func_o   (func),
      .rs_o     (rs),
      .rt_o     (rt),
      .rd_o     (rd),
      .imm_o    (imm)
   );

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign instr_valid = valid_q;
   assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed plan scenarios, then randomized traffic.
module tb_instr_fetch_unit;

   typedef struct packed {
      logic [15:0] word;
      logic [15:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [3:0]  opCode;
   logic [2:0]  func;
   logic [2:0]  rs;
   logic [2:0]  rt;
   logic [2:0]  rd;
   logic [5:0]  imm;
   logic [15:0] pc_out;
   logic        redirect;
   logic [15:0] redirect_pc;

   int          checks = 0;
   int          errors = 0;
   int          delivered = 0;

   logic [15:0] mem [0:65535];
   exp_t        sb_q[$];

   // Reference model: next address to be fetched, and whether the request in flight is spoiled.
   logic [15:0] exp_pc;
   logic        dirty;
   logic [15:0] tgt;

   instr_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .opCode      (opCode),
      .func        (func),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .imm         (imm),
      .pc_out      (pc_out),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a falling edge: apply inputs, advance the model with what the next rising
   // edge will see, then wait for the following falling edge.
   task automatic cyc(input bit ack, input bit redir, input logic [15:0] rpc, input bit rdy);
      imem_ack    = ack;
      imem_rdata  = mem[imem_addr];
      redirect    = redir;
      redirect_pc = rpc;
      instr_ready = rdy;
      if (!rst_n) begin
         exp_pc = 16'h0000;
         dirty  = 1'b0;
         sb_q.delete();
      end else if (imem_req) begin
         check("imem_addr", imem_addr, exp_pc);
         if (redir) begin
            dirty = 1'b1;
            tgt   = rpc;
         end
         if (ack) begin
            if (dirty) begin
               exp_pc = tgt;
               dirty  = 1'b0;
            end else begin
               sb_q.push_back('{word: mem[exp_pc], pc: exp_pc});
               exp_pc = exp_pc + 16'd1;
            end
         end
      end else if (redir) begin
         exp_pc = rpc;
      end
      @(negedge clk);
   endtask

   // Monitor: compares each newly presented instruction and checks held ones stay stable.
   initial begin
      logic        prev_valid;
      logic [37:0] snap;
      exp_t        e;
      int          w;
      prev_valid = 1'b0;
      snap       = '0;
      forever begin
         @(posedge clk);
         #1;
         if (instr_valid && imem_req) check("req_and_valid", 1, 0);
         if (instr_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               e = sb_q.pop_front();
               w = int'(e.word);
               delivered++;
               check("opCode", opCode, w / 4096);
               check("rs", rs, (w / 512) % 8);
               check("rt", rt, (w / 64) % 8);
               check("rd", rd, (w / 8) % 8);
               check("func", func, w % 8);
               check("imm", imm, w % 64);
               check("pc_out", pc_out, e.pc);
            end
            snap = {opCode, rs, rt, rd, func, imm, pc_out};
         end else if (instr_valid) begin
            check("hold_stable", {opCode, rs, rt, rd, func, imm, pc_out}, snap);
         end
         prev_valid = instr_valid;
      end
   end

   initial begin
      bit          r_ack;
      bit          r_red;
      logic [15:0] r_pc;
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[16'h0000] = 16'h0123;
      mem[16'h0001] = 16'h1045;
      mem[16'h0002] = 16'h5ABC;
      mem[16'h0003] = 16'hFFFF;
      rst_n = 1'b0;
      imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
      exp_pc = '0; dirty = 1'b0; tgt = '0;
      @(negedge clk);

      // Reset with a stray ack held high
      repeat (3) cyc(1, 0, 16'h0, 0);
      check("rst_req", imem_req, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_pc_out", pc_out, 0);
      rst_n = 1'b1;
      cyc(0, 0, 16'h0, 1);
      check("first_req", imem_req, 1);
      check("first_addr", imem_addr, 16'h0000);

      // Sequential fetch
      cyc(1, 0, 16'h0, 1);
      check("seq0_valid", instr_valid, 1);
      check("seq0_rt", rt, 4);
      check("seq0_imm", imm, 6'h23);
      cyc(0, 0, 16'h0, 1);
      check("seq_gap_valid", instr_valid, 0);
      cyc(1, 0, 16'h0, 1);
      check("seq1_valid", instr_valid, 1);
      check("seq1_opcode", opCode, 1);

      // Backpressure
      repeat (5) begin
         cyc(0, 0, 16'h0, 0);
         check("bp_valid", instr_valid, 1);
         check("bp_req", imem_req, 0);
         check("bp_pc_out", pc_out, 16'h0001);
      end
      cyc(0, 0, 16'h0, 1);
      check("bp_next_addr", imem_addr, 16'h0002);

      // Wait states
      repeat (3) begin
         cyc(0, 0, 16'h0, 1);
         check("ws_req", imem_req, 1);
         check("ws_valid", instr_valid, 0);
      end
      cyc(1, 0, 16'h0, 1);
      check("ws_capture_pc", pc_out, 16'h0002);
      cyc(0, 0, 16'h0, 1);

      // Redirect during a request, then latest-wins
      cyc(0, 1, 16'h0040, 1);
      check("rd_addr_hold", imem_addr, 16'h0003);
      cyc(1, 0, 16'h0, 1);
      check("rd_discard_valid", instr_valid, 0);
      check("rd_ir_kept", opCode, 4'h5);
      check("rd_new_addr", imem_addr, 16'h0040);
      cyc(0, 1, 16'h0070, 1);
      cyc(0, 1, 16'h0080, 1);
      cyc(1, 0, 16'h0, 1);
      check("rd_latest_addr", imem_addr, 16'h0080);

      // Wrap and redirect while holding
      cyc(0, 1, 16'hFFFF, 1);
      cyc(1, 0, 16'h0, 1);
      cyc(1, 0, 16'h0, 0);
      check("wrap_pc_out", pc_out, 16'hFFFF);
      cyc(0, 0, 16'h0, 1);
      check("wrap_addr", imem_addr, 16'h0000);
      cyc(1, 0, 16'h0, 0);
      cyc(0, 1, 16'h1234, 1);
      check("hold_rd_valid", instr_valid, 0);
      check("hold_rd_addr", imem_addr, 16'h1234);

      // Randomized traffic, including stray acks and occasional mid-operation resets
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            cyc(1'($urandom_range(0, 1)), 0, 16'h0, 1'($urandom_range(0, 1)));
            cyc(0, 0, 16'h0, 0);
            rst_n = 1'b1;
         end
         r_ack = imem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
         r_red = ($urandom_range(0, 9) == 0);
         r_pc  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         cyc(r_ack, r_red, r_pc, 1'($urandom_range(0, 1)));
      end
      cyc(0, 0, 16'h0, 0);
      check("sb_drained", sb_q.size(), 0);
      check("progress", delivered > 100, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
